// File: rtl/pwr_domain_sequencer.sv
// Power-down/up sequencer for the switchable MIPS domain: answers sw_ctrl_net with
// clock-gate, isolate, save, switch-off, then switch-on, settle, restore, de-isolate.
module pwr_domain_sequencer #(
  parameter int ISO_CYC     = 2,
  parameter int SETTLE_CYC  = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_ctrl_net,
  input  logic       pswitch_ack,
  output logic       clk_en,
  output logic       iso_en,
  output logic       ret_save,
  output logic       ret_restore,
  output logic       pswitch_en,
  output logic       sw_enable,
  output logic       err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    ON       = 4'd0,
    CLK_STOP = 4'd1,
    ISO      = 4'd2,
    SAVE     = 4'd3,
    SW_OFF   = 4'd4,
    OFF      = 4'd5,
    SW_ON    = 4'd6,
    SETTLE   = 4'd7,
    RESTORE  = 4'd8,
    ISO_REL  = 4'd9
  } state_t;

  localparam logic [CNT_W-1:0] ISO_LAST    = CNT_W'(ISO_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);

  state_t           cur;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             err_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= ON;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cur <= nxt;
      cnt <= (nxt != cur) ? '0 : cnt + 1'b1;
      err <= err_nxt;
    end
  end

  always_comb begin
    nxt     = cur;
    err_nxt = err;
    case (cur)
      ON:       if (sw_ctrl_net) nxt = CLK_STOP;
      CLK_STOP: nxt = sw_ctrl_net ? ISO : ISO_REL;
      ISO: begin
        if (!sw_ctrl_net)         nxt = ISO_REL;
        else if (cnt == ISO_LAST) nxt = SAVE;
      end
      SAVE:     nxt = SW_OFF;
      // A stuck ack is flagged but the sequence still advances.
      SW_OFF: begin
        if (!pswitch_ack) begin
          nxt = OFF;
        end else if (cnt == ACK_LAST) begin
          nxt     = OFF;
          err_nxt = 1'b1;
        end
      end
      OFF:      if (!sw_ctrl_net) nxt = SW_ON;
      SW_ON: begin
        if (pswitch_ack) begin
          nxt = SETTLE;
        end else if (cnt == ACK_LAST) begin
          nxt     = SETTLE;
          err_nxt = 1'b1;
        end
      end
      SETTLE:   if (cnt == SETTLE_LAST) nxt = RESTORE;
      RESTORE:  nxt = ISO_REL;
      ISO_REL:  nxt = ON;
      default:  nxt = ON;
    endcase
  end

  always_comb begin
    clk_en      = 1'b0;
    sw_enable   = 1'b0;
    iso_en      = 1'b0;
    ret_save    = 1'b0;
    ret_restore = 1'b0;
    pswitch_en  = 1'b1;
    case (cur)
      ON: begin
        clk_en    = 1'b1;
        sw_enable = 1'b1;
      end
      ISO, SETTLE, SW_ON: iso_en = 1'b1;
      SAVE: begin
        iso_en   = 1'b1;
        ret_save = 1'b1;
      end
      SW_OFF, OFF: begin
        iso_en     = 1'b1;
        pswitch_en = 1'b0;
      end
      RESTORE: begin
        iso_en      = 1'b1;
        ret_restore = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = cur;

endmodule
